// File: rtl/icache_responder.sv
// Direct-mapped instruction cache for the fetch port. Serves hits combinationally and refills
// a whole line from backing memory through a ready-handshake read port on a miss.
module icache_responder #(
    parameter int unsigned SETS        = 16,
    parameter int unsigned BLOCK_WORDS = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             imemREN,
    input  logic [31:0]      imemaddr,
    output logic [31:0]      imemload,
    output logic             ihit,
    input  logic             flush,
    output logic             mem_ren,
    output logic [31:0]      mem_addr,
    input  logic [31:0]      mem_load,
    input  logic             mem_ready,
    output logic [CNT_W-1:0] miss_count
);

    localparam int unsigned WOFF  = $clog2(BLOCK_WORDS);
    localparam int unsigned OFF_W = (WOFF == 0) ? 1 : WOFF;
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 30 - WOFF - IDX_W;

    typedef enum logic [0:0] {StIdle, StFill} state_e;

    state_e             state_q;
    logic [SETS-1:0]    valid_q;
    logic [OFF_W-1:0]   cnt_q;
    logic [31:0]        base_q;
    logic [CNT_W-1:0]   miss_count_q;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [31:0]        data_q [SETS][BLOCK_WORDS];

    logic [OFF_W-1:0]   req_off;
    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               req_hit;
    logic               fill_last;

    // With single-word lines there is no offset field; the 1-bit offset is tied to zero.
    assign req_off   = (WOFF == 0) ? '0 : imemaddr[2 +: OFF_W];
    assign req_idx   = imemaddr[2 + WOFF +: IDX_W];
    assign req_tag   = imemaddr[31 -: TAG_W];
    assign fill_idx  = base_q[2 + WOFF +: IDX_W];
    assign fill_tag  = base_q[31 -: TAG_W];
    assign fill_last = (cnt_q == OFF_W'(BLOCK_WORDS - 1));

    assign req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign ihit     = (state_q == StIdle) && imemREN && req_hit && !flush;
    assign imemload = ihit ? data_q[req_idx][req_off] : 32'h0;

    assign mem_ren    = (state_q == StFill);
    assign mem_addr   = mem_ren ? (base_q + {{(30 - OFF_W){1'b0}}, cnt_q, 2'b00}) : 32'h0;
    assign miss_count = miss_count_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            valid_q      <= '0;
            cnt_q        <= '0;
            base_q       <= '0;
            miss_count_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (flush) begin
                        valid_q <= '0;
                    end else if (imemREN && !req_hit) begin
                        base_q  <= {imemaddr[31:2 + WOFF], {(2 + WOFF){1'b0}}};
                        cnt_q   <= '0;
                        state_q <= StFill;
                        if (miss_count_q != '1) begin
                            miss_count_q <= miss_count_q + CNT_W'(1);
                        end
                    end
                end
                StFill: begin
                    // Abandoning an in-flight read is safe: memory reads have no side effects.
                    if (flush) begin
                        valid_q <= '0;
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else if (mem_ready) begin
                        if (fill_last) begin
                            valid_q[fill_idx] <= 1'b1;
                            cnt_q             <= '0;
                            state_q           <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + OFF_W'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Arrays are not reset; a stale tag is harmless because its valid bit gates the hit.
    always_ff @(posedge CLK) begin
        if (state_q == StFill && mem_ready) begin
            data_q[fill_idx][cnt_q] <= mem_load;
            if (fill_last) begin
                tag_q[fill_idx] <= fill_tag;
            end
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: hit/miss timing, stalls, eviction, flush, reset and
// miss counter saturation, using a 4-bit miss counter.
module tb_icache_responder;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = 32'h0;
    logic [31:0] imemload;
    logic        ihit;
    logic        flush = 1'b0;
    logic        mem_ren;
    logic [31:0] mem_addr;
    logic [31:0] mem_load = 32'h0;
    logic        mem_ready = 1'b0;
    logic [3:0]  miss_count;

    int tests_run = 0;
    int tests_failed = 0;

    icache_responder #(
        .SETS       (16),
        .BLOCK_WORDS(2),
        .CNT_W      (4)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .imemREN   (imemREN),
        .imemaddr  (imemaddr),
        .imemload  (imemload),
        .ihit      (ihit),
        .flush     (flush),
        .mem_ren   (mem_ren),
        .mem_addr  (mem_addr),
        .mem_load  (mem_load),
        .mem_ready (mem_ready),
        .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'hC0DE0000;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; imemREN = 1'b0; imemaddr = 32'h0; flush = 1'b0;
        mem_ready = 1'b0; mem_load = 32'h0;
        tick(); tick();
        RST = 1'b0;
    endtask

    // Serves one line at base, holding mem_ready low for 'stall' cycles before each word.
    task automatic fill_block(input logic [31:0] base, input int stall);
        for (int w = 0; w < 2; w++) begin
            for (int s = 0; s <= stall; s++) begin
                mem_ready = (s == stall);
                mem_load  = (s == stall) ? mdata(base + 32'(4 * w)) : 32'hDEADBEEF;
                #1;
                tests_run++;
                if (mem_ren !== 1'b1 || mem_addr !== base + 32'(4 * w) || ihit !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL fill: mem_ren=%b mem_addr=%h ihit=%b, need 1 %h 0",
                             mem_ren, mem_addr, ihit, base + 32'(4 * w));
                end
                tick();
            end
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests_run++;
        if (ihit !== 1'b0 || imemload !== 32'h0 || mem_ren !== 1'b0 || mem_addr !== 32'h0 ||
            miss_count !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset: ihit=%b load=%h ren=%b addr=%h cnt=%0d, need all zero",
                     ihit, imemload, mem_ren, mem_addr, miss_count);
        end
    endtask

    task automatic test_cold_miss();
        do_reset();
        imemREN = 1'b1; imemaddr = 32'h100;
        #1;
        tests_run++;
        if (ihit !== 1'b0 || mem_ren !== 1'b0) begin
            tests_failed++;
            $display("FAIL cold_detect: ihit=%b mem_ren=%b, need 0 0", ihit, mem_ren);
        end
        tick();
        fill_block(32'h100, 0);
        #1;
        tests_run++;
        if (ihit !== 1'b1 || imemload !== 32'hC0DE0100) begin
            tests_failed++;
            $display("FAIL cold_hit: ihit=%b load=%h, need 1 c0de0100", ihit, imemload);
        end
        imemaddr = 32'h104;
        #1;
        tests_run++;
        if (ihit !== 1'b1 || imemload !== 32'hC0DE0104 || miss_count !== 4'd1) begin
            tests_failed++;
            $display("FAIL cold_word1: ihit=%b load=%h cnt=%0d, need 1 c0de0104 1",
                     ihit, imemload, miss_count);
        end
        imemREN = 1'b0;
        #1;
        tests_run++;
        if (imemload !== 32'h0 || ihit !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_load: ihit=%b load=%h, need 0 0", ihit, imemload);
        end
    endtask

    // 3 stall cycles per word: one detect cycle plus 8 FILL cycles before the hit.
    task automatic test_stall();
        do_reset();
        imemREN = 1'b1; imemaddr = 32'h200;
        tick();
        fill_block(32'h200, 3);
        #1;
        tests_run++;
        if (ihit !== 1'b1 || imemload !== 32'hC0DE0200) begin
            tests_failed++;
            $display("FAIL stall_hit: ihit=%b load=%h, need 1 c0de0200", ihit, imemload);
        end
    endtask

    task automatic test_conflict();
        do_reset();
        imemREN = 1'b1; imemaddr = 32'h100;
        tick(); fill_block(32'h100, 0);
        imemaddr = 32'h180;
        #1;
        tests_run++;
        if (ihit !== 1'b0) begin
            tests_failed++;
            $display("FAIL conflict_miss: ihit=%b, need 0", ihit);
        end
        tick(); fill_block(32'h180, 0);
        #1;
        tests_run++;
        if (ihit !== 1'b1 || imemload !== 32'hC0DE0180) begin
            tests_failed++;
            $display("FAIL conflict_hit: ihit=%b load=%h, need 1 c0de0180", ihit, imemload);
        end
        imemaddr = 32'h100;
        #1;
        tests_run++;
        if (ihit !== 1'b0) begin
            tests_failed++;
            $display("FAIL evicted: ihit=%b, need 0", ihit);
        end
        tick(); fill_block(32'h100, 0);
        #1;
        tests_run++;
        if (ihit !== 1'b1 || miss_count !== 4'd3) begin
            tests_failed++;
            $display("FAIL conflict_cnt: ihit=%b cnt=%0d, need 1 3", ihit, miss_count);
        end
    endtask

    task automatic test_flush_mid_fill();
        do_reset();
        imemREN = 1'b1; imemaddr = 32'h100;
        tick(); fill_block(32'h100, 0);
        imemaddr = 32'h300;
        tick();
        mem_ready = 1'b1; mem_load = mdata(32'h300);
        tick();
        mem_ready = 1'b0; flush = 1'b1;
        #1;
        tests_run++;
        if (mem_ren !== 1'b1 || mem_addr !== 32'h304 || ihit !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_cycle: ren=%b addr=%h ihit=%b, need 1 304 0",
                     mem_ren, mem_addr, ihit);
        end
        tick();
        flush = 1'b0; imemREN = 1'b0;
        #1;
        tests_run++;
        if (mem_ren !== 1'b0 || mem_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL flush_drop: ren=%b addr=%h, need 0 0", mem_ren, mem_addr);
        end
        imemREN = 1'b1;
        #1;
        tests_run++;
        if (ihit !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_300: ihit=%b, need 0", ihit);
        end
        imemaddr = 32'h100;
        #1;
        tests_run++;
        if (ihit !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_100: ihit=%b, need 0", ihit);
        end
        // Miss and flush together: flush wins, no fill, counter unchanged.
        flush = 1'b1;
        tick();
        flush = 1'b0; imemREN = 1'b0;
        #1;
        tests_run++;
        if (mem_ren !== 1'b0 || miss_count !== 4'd2) begin
            tests_failed++;
            $display("FAIL miss_flush: ren=%b cnt=%0d, need 0 2", mem_ren, miss_count);
        end
    endtask

    task automatic test_addr_change();
        do_reset();
        imemREN = 1'b1; imemaddr = 32'h400;
        tick();
        imemaddr = 32'h500;
        fill_block(32'h400, 0);
        #1;
        tests_run++;
        if (ihit !== 1'b0 || mem_ren !== 1'b0) begin
            tests_failed++;
            $display("FAIL change_idle: ihit=%b ren=%b, need 0 0", ihit, mem_ren);
        end
        tick();
        fill_block(32'h500, 0);
        #1;
        tests_run++;
        if (ihit !== 1'b1 || imemload !== 32'hC0DE0500 || miss_count !== 4'd2) begin
            tests_failed++;
            $display("FAIL change_hit: ihit=%b load=%h cnt=%0d, need 1 c0de0500 2",
                     ihit, imemload, miss_count);
        end
        imemREN = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        do_reset();
        imemREN = 1'b1; imemaddr = 32'h100;
        tick(); fill_block(32'h100, 0);
        imemaddr = 32'h600;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0; imemREN = 1'b0;
        #1;
        tests_run++;
        if (mem_ren !== 1'b0 || miss_count !== 4'd0) begin
            tests_failed++;
            $display("FAIL rst_fill: ren=%b cnt=%0d, need 0 0", mem_ren, miss_count);
        end
        imemREN = 1'b1; imemaddr = 32'h100;
        #1;
        tests_run++;
        if (ihit !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_valid: ihit=%b, need 0", ihit);
        end
        imemREN = 1'b0;
    endtask

    task automatic test_saturation();
        logic [31:0] a;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            a = 32'h1000 + 32'(i) * 32'h80;
            imemREN = 1'b1; imemaddr = a;
            tick();
            fill_block(a, 0);
            if (i == 14) begin
                tests_run++;
                if (miss_count !== 4'd15) begin
                    tests_failed++;
                    $display("FAIL sat_15: cnt=%0d, need 15", miss_count);
                end
            end
        end
        imemREN = 1'b0;
        #1;
        tests_run++;
        if (miss_count !== 4'd15) begin
            tests_failed++;
            $display("FAIL sat_17: cnt=%0d, need 15", miss_count);
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_stall();
        test_conflict();
        test_flush_mid_fill();
        test_addr_change();
        test_reset_mid_fill();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
